// File: rtl/btn_debouncer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_debouncer: per-button 2-flop sync, counter debounce, press/release
// pulses and optional auto-repeat.                           Revision: 1.0
// ---------------------------------------------------------------------------
module btn_debouncer #(
  parameter int N_BTN        = 4,
  parameter int STABLE_CNT   = 4,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    HELD    = 2'd2,
    CHK_LO  = 2'd3
  } state_t;

  localparam logic [7:0] c_stable_last = 8'(STABLE_CNT - 1);
  localparam logic [7:0] c_delay       = 8'(REPEAT_DELAY);
  // A rate longer than the delay would underflow the reload; clamp to zero.
  localparam logic [7:0] c_reload      = (REPEAT_RATE >= REPEAT_DELAY) ? 8'd0 :
                                         8'(REPEAT_DELAY - REPEAT_RATE);
  localparam bit         c_repeat_en   = (REPEAT_DELAY != 0);

  logic [N_BTN-1:0] w_press_nxt;

  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      state_t     r_state, w_state_nxt;
      logic       r_s1, r_s2;
      logic [7:0] r_cnt, w_cnt_nxt;
      logic [7:0] r_hold, w_hold_nxt;
      logic       r_level, r_press, r_release;
      logic       w_press, w_release;

      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = 8'd0;
        w_hold_nxt  = r_hold;
        w_press     = 1'b0;
        w_release   = 1'b0;
        case (r_state)
          IDLE_LO, CHK_HI: begin
            w_hold_nxt = 8'd0;
            if (!r_s2) begin
              w_state_nxt = IDLE_LO;
            end else if (r_cnt == c_stable_last) begin
              w_state_nxt = HELD;
              w_press     = 1'b1;
            end else begin
              w_state_nxt = CHK_HI;
              w_cnt_nxt   = r_cnt + 8'd1;
            end
          end
          default: begin
            if (r_s2) begin
              w_state_nxt = HELD;
              // Hold time advances only in HELD; a pending release check freezes it.
              if (c_repeat_en && (r_state == HELD)) begin
                if (r_hold == c_delay - 8'd1) begin
                  w_press    = 1'b1;
                  w_hold_nxt = c_reload;
                end else if (r_hold != 8'hFF) begin
                  w_hold_nxt = r_hold + 8'd1;
                end
              end
            end else if (r_cnt == c_stable_last) begin
              w_state_nxt = IDLE_LO;
              w_release   = 1'b1;
              w_hold_nxt  = 8'd0;
            end else begin
              w_state_nxt = CHK_LO;
              w_cnt_nxt   = r_cnt + 8'd1;
            end
          end
        endcase
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_s1      <= 1'b0;
          r_s2      <= 1'b0;
          r_state   <= IDLE_LO;
          r_cnt     <= 8'd0;
          r_hold    <= 8'd0;
          r_level   <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_s1      <= btn_raw[i];
          r_s2      <= r_s1;
          r_state   <= w_state_nxt;
          r_cnt     <= w_cnt_nxt;
          r_hold    <= w_hold_nxt;
          r_level   <= (w_state_nxt == HELD) || (w_state_nxt == CHK_LO);
          r_press   <= w_press;
          r_release <= w_release;
        end
      end

      assign w_press_nxt[i] = w_press;
      assign btn_level[i]   = r_level;
      assign btn_press[i]   = r_press;
      assign btn_release[i] = r_release;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |w_press_nxt;
    end
  end

endmodule
`default_nettype wire
